// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined two's-complement adder/subtractor, valid/ready.
// Optional macro PIPE_ADDSUB_SAT_EN: saturate sum on signed overflow.
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   // xa: finished sum chunks below, untouched A chunks above
   logic [WIDTH-1:0] xa [STAGES];
   logic [WIDTH-1:0] xb [STAGES];
   logic             xc [STAGES];
   logic             xv [STAGES];
   logic             ov_q;

   logic [WIDTH-1:0] ia [STAGES];
   logic [WIDTH-1:0] ib [STAGES];
   logic             ic [STAGES];
   logic [WIDTH-1:0] na [STAGES];
   logic             nc [STAGES];
   logic [CW:0]      t  [STAGES];

   logic             msb_cin;
   logic             ovf_d;
   logic [WIDTH-1:0] last_d;
   logic             advance;

   assign advance   = !(xv[STAGES-1] && !out_ready);
   assign in_ready  = advance;
   assign out_valid = xv[STAGES-1];
   assign sum       = xa[STAGES-1];
   assign co        = xc[STAGES-1];
   assign ovf       = ov_q;

   // Stage inputs: prepared operands feed stage 0, registers feed the rest
   always_comb begin
      ia[0] = a;
      ib[0] = sub ? ~b : b;
      ic[0] = sub ? ~ci : ci;
      for (int k = 1; k < STAGES; k++) begin
         ia[k] = xa[k-1];
         ib[k] = xb[k-1];
         ic[k] = xc[k-1];
      end
   end

   // Each stage adds its own chunk and splices it into the word
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         t[k] = {1'b0, ia[k][k*CW +: CW]}
              + {1'b0, ib[k][k*CW +: CW]}
              + {{CW{1'b0}}, ic[k]};
         na[k] = ia[k];
         na[k][k*CW +: CW] = t[k][CW-1:0];
         nc[k] = t[k][CW];
      end
   end

   // Last stage: signed overflow and optional saturation
   always_comb begin
      msb_cin = ia[STAGES-1][WIDTH-1]
              ^ ib[STAGES-1][WIDTH-1]
              ^ na[STAGES-1][WIDTH-1];
      ovf_d   = msb_cin ^ nc[STAGES-1];
      last_d  = na[STAGES-1];
`ifdef PIPE_ADDSUB_SAT_EN
      if (ovf_d) begin
         if (ia[STAGES-1][WIDTH-1])
            last_d = {1'b1, {(WIDTH-1){1'b0}}};
         else
            last_d = {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Register stages; everything, bubbles included, holds during a stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            xa[k] <= '0;
            xb[k] <= '0;
            xc[k] <= 1'b0;
            xv[k] <= 1'b0;
         end
         ov_q <= 1'b0;
      end else if (advance) begin
         xv[0] <= in_valid;
         for (int k = 1; k < STAGES; k++)
            xv[k] <= xv[k-1];
         for (int k = 0; k < STAGES; k++) begin
            xa[k] <= na[k];
            xb[k] <= ib[k];
            xc[k] <= nc[k];
         end
         xa[STAGES-1] <= last_d;
         ov_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed 8-bit vectors on three depths,
// plus a 32-bit backpressured stream and mid-flight reset.
module tb_pipe_addsub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 32-bit default instance
   logic        v32, rdy32, ov32, or32;
   logic [31:0] a32, b32, s32;
   logic        ci32, sub32, co32, of32;

   // 8-bit instances share inputs: idx 0 = 1 stage, 1 = 2, 2 = 4
   logic       v8, or8, ci8, sub8;
   logic [7:0] a8, b8;
   logic       rdy8 [3];
   logic       ov8  [3];
   logic [7:0] s8   [3];
   logic       co8  [3];
   logic       of8  [3];

   pipe_addsub #(.WIDTH(32), .STAGES(4)) u32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
      .a(a32), .b(b32), .ci(ci32), .sub(sub32),
      .out_valid(ov32), .out_ready(or32),
      .sum(s32), .co(co32), .ovf(of32));

   pipe_addsub #(.WIDTH(8), .STAGES(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8[0]),
      .a(a8), .b(b8), .ci(ci8), .sub(sub8),
      .out_valid(ov8[0]), .out_ready(or8),
      .sum(s8[0]), .co(co8[0]), .ovf(of8[0]));

   pipe_addsub #(.WIDTH(8), .STAGES(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8[1]),
      .a(a8), .b(b8), .ci(ci8), .sub(sub8),
      .out_valid(ov8[1]), .out_ready(or8),
      .sum(s8[1]), .co(co8[1]), .ovf(of8[1]));

   pipe_addsub #(.WIDTH(8), .STAGES(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8[2]),
      .a(a8), .b(b8), .ci(ci8), .sub(sub8),
      .out_valid(ov8[2]), .out_ready(or8),
      .sum(s8[2]), .co(co8[2]), .ovf(of8[2]));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0] a, b;
      logic       ci, sub;
      logic [7:0] s, ss;
      logic       co, ov;
   } vec_t;

   vec_t tv [7];

   typedef struct packed {
      logic [31:0] s;
      logic        c, o;
   } r32_t;

   r32_t q[$];

   function automatic logic [7:0] esum(input vec_t v);
`ifdef PIPE_ADDSUB_SAT_EN
      return v.ss;
`else
      return v.s;
`endif
   endfunction

   function automatic r32_t model32(input logic [31:0] x,
                                    input logic [31:0] y,
                                    input logic c, input logic m);
      logic [31:0] oy;
      logic [32:0] r;
      r32_t res;
      oy = m ? ~y : y;
      r = {1'b0, x} + {1'b0, oy} + {32'd0, (m ? ~c : c)};
      res.s = r[31:0];
      res.c = r[32];
      res.o = (x[31] == oy[31]) && (r[31] != x[31]);
`ifdef PIPE_ADDSUB_SAT_EN
      if (res.o)
         res.s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input int j, input int i);
      check($sformatf("v8_ov%0d_%0d", j, i), ov8[j], 1'b1);
      check($sformatf("v8_s%0d_%0d", j, i), s8[j], esum(tv[i]));
      check($sformatf("v8_co%0d_%0d", j, i), co8[j], tv[i].co);
      check($sformatf("v8_of%0d_%0d", j, i), of8[j], tv[i].ov);
   endtask

   task automatic set8(input int i);
      a8 = tv[i].a;
      b8 = tv[i].b;
      ci8 = tv[i].ci;
      sub8 = tv[i].sub;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      r32_t r;
      logic [33:0] prev;
      logic stalled;
      int acc, cyc;

      //            a      b     ci    sub   s      sat    co    ov
      tv[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
      tv[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 8'hFD, 1'b0, 1'b0};
      tv[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
      tv[4] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0};
      tv[5] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b1, 1'b0};
      tv[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};

      rst = 1'b1;
      v32 = 0; a32 = 0; b32 = 0; ci32 = 0; sub32 = 0; or32 = 1;
      v8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; or8 = 1;
      tick();
      tick();
      check("rst_ov32", ov32, 1'b0);
      check("rst_s32", s32, 32'd0);
      check("rst_co32", co32, 1'b0);
      check("rst_of32", of32, 1'b0);
      check("rst_rdy32", rdy32, 1'b1);
      for (int j = 0; j < 3; j++) begin
         check($sformatf("rst_ov8_%0d", j), ov8[j], 1'b0);
         check($sformatf("rst_s8_%0d", j), s8[j], 8'd0);
         check($sformatf("rst_rdy8_%0d", j), rdy8[j], 1'b1);
      end
      rst = 1'b0;
      tick();

      // Isolated beats: latency 1, 2 and 4
      for (int i = 0; i < 7; i++) begin
         set8(i);
         v8 = 1'b1;
         tick();
         v8 = 1'b0;
         chk8(0, i);
         check($sformatf("lat2_early_%0d", i), ov8[1], 1'b0);
         tick();
         chk8(1, i);
         check($sformatf("lat1_bubble_%0d", i), ov8[0], 1'b0);
         tick();
         check($sformatf("lat4_early_%0d", i), ov8[2], 1'b0);
         tick();
         chk8(2, i);
      end
      tick();

      // Back-to-back beats, full throughput
      for (int i = 0; i < 7; i++) begin
         set8(i);
         v8 = 1'b1;
         tick();
         chk8(0, i);
         if (i > 0) chk8(1, i - 1);
      end
      v8 = 1'b0;
      tick();
      chk8(1, 6);
      check("b2b_tail", ov8[0], 1'b0);
      tick();
      tick();
      tick();

      // 32-bit stream with random backpressure
      acc = 0;
      cyc = 0;
      stalled = 1'b0;
      prev = '0;
      while (acc < 100 && cyc < 3000) begin
         if (stalled) begin
            check("stall_ov", ov32, 1'b1);
            check("stall_hold", {s32, co32, of32}, prev);
         end
         v32 = ($urandom_range(0, 3) != 0);
         a32 = $urandom;
         b32 = $urandom;
         ci32 = 1'($urandom_range(0, 1));
         sub32 = 1'($urandom_range(0, 1));
         or32 = 1'($urandom_range(0, 1));
         #1;
         if (ov32 && or32) begin
            if (q.size() == 0) begin
               check("dup", 1'b1, 1'b0);
            end else begin
               r = q.pop_front();
               check("stream", {s32, co32, of32}, {r.s, r.c, r.o});
            end
         end
         if (ov32 && !or32)
            check("stall_rdy", rdy32, 1'b0);
         if (v32 && rdy32) begin
            q.push_back(model32(a32, b32, ci32, sub32));
            acc++;
         end
         stalled = ov32 && !or32;
         prev = {s32, co32, of32};
         @(posedge clk);
         #1;
         cyc++;
      end
      check("stream_budget", (acc >= 100), 1'b1);
      if (stalled) check("stall_hold_end", {s32, co32, of32}, prev);
      v32 = 1'b0;
      or32 = 1'b1;
      for (int n = 0; n < 20 && q.size() > 0; n++) begin
         #1;
         if (ov32) begin
            r = q.pop_front();
            check("drain", {s32, co32, of32}, {r.s, r.c, r.o});
         end
         tick();
      end
      check("drain_empty", q.size(), 0);
      check("drain_idle", ov32, 1'b0);

      // Four beats in flight, then reset
      for (int i = 0; i < 4; i++) begin
         v32 = 1'b1;
         a32 = $urandom;
         b32 = $urandom;
         tick();
      end
      v32 = 1'b0;
      rst = 1'b1;
      #1;
      check("mrst_ov", ov32, 1'b0);
      check("mrst_s", s32, 32'd0);
      check("mrst_co", co32, 1'b0);
      check("mrst_of", of32, 1'b0);
      check("mrst_rdy", rdy32, 1'b1);
      tick();
      rst = 1'b0;
      a32 = 32'h1234_5678;
      b32 = 32'h1111_1111;
      ci32 = 1'b1;
      sub32 = 1'b0;
      v32 = 1'b1;
      tick();
      v32 = 1'b0;
      check("post_n0", ov32, 1'b0);
      tick();
      check("post_n1", ov32, 1'b0);
      tick();
      check("post_n2", ov32, 1'b0);
      tick();
      check("post_ov", ov32, 1'b1);
      check("post_s", s32, 32'h2345_678A);
      check("post_co", co32, 1'b0);
      check("post_of", of32, 1'b0);
      tick();
      check("post_alone", ov32, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
